tpu_stream_core: RTL and testbench

Parametrised successor to the serial-bit TinyTPU top level. It accepts operand vectors over a word-parallel valid/ready stream and accumulates an N×N output-stationary product C = A·B over a runtime inner dimension K (1..K_MAX), with selectable signed/unsigned arithmetic. After a fixed drain it streams the N·N results out row-major over a second valid/ready port. It sits between the host-side DMA/FIFO and the result FIFO, replacing the bit-serial control/output_control pair.

---
 rtl/tpu_stream_core_if.sv | 32 +++
 rtl/tpu_stream_core.sv | 244 ++++++++++++++++++++++++
 tb/tb_tpu_stream_core.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_stream_core_if.sv
// Operand and result stream bundle for tpu_stream_core.
// master drives operands/acks, slave is the core side.
interface tpu_stream_core_if #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int K_MAX = 4
);
    localparam int ACC_W = 2 * D_W + $clog2(K_MAX);

    logic             start;
    logic             signed_en;
    logic             in_valid;
    logic             in_ready;
    logic [N*D_W-1:0] in_a;
    logic [N*D_W-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_last;
    logic             busy;

    modport master (
        output start, signed_en, in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  start, signed_en, in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/tpu_stream_core.sv
// Output-stationary NxN systolic matrix core with skewed operand
// entry, fixed drain and row-major valid/ready result streaming.
module tpu_stream_core #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int K_MAX = 4
) (
    input logic            clk,
    input logic            rst,
    tpu_stream_core_if.slave bus
);
    localparam int ACC_W = 2 * D_W + $clog2(K_MAX);
    localparam int PW    = ACC_W + 2;
    localparam int BW    = $clog2(K_MAX);
    localparam int DCW   = $clog2(2 * N - 1);
    localparam int NE    = N * N;
    localparam int EW    = $clog2(NE);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             sgn_q, sgn_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [EW-1:0]    elem_q, elem_d;
    logic [EW-1:0]    elem_nx;
    logic             clear;

    logic             fire;
    logic [N*D_W-1:0] a_in, b_in;
    logic [N*D_W-1:0] a_row, b_col;
    logic [D_W-1:0]   a_at [N][N];
    logic [D_W-1:0]   b_at [N][N];
    logic [D_W-1:0]   a_pass_q [N][N-1];
    logic [D_W-1:0]   a_pass_d [N][N-1];
    logic [D_W-1:0]   b_pass_q [N-1][N];
    logic [D_W-1:0]   b_pass_d [N-1][N];
    logic [ACC_W-1:0] acc_q [NE];
    logic [ACC_W-1:0] acc_d [NE];

    // Idle cycles feed zeros so they add nothing to the sums.
    assign fire = bus.in_valid & in_ready_q;
    assign a_in = fire ? bus.in_a : '0;
    assign b_in = fire ? bus.in_b : '0;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

    // Extend per mode, multiply wide, wrap into the accumulator width.
    function automatic logic [ACC_W-1:0] mul_ext(
        input logic [D_W-1:0] a,
        input logic [D_W-1:0] b,
        input logic           sgn
    );
        logic signed [D_W:0]  ae, be;
        logic signed [PW-1:0] ax, bx, p;
        ae = {sgn & a[D_W-1], a};
        be = {sgn & b[D_W-1], b};
        ax = PW'(ae);
        bx = PW'(be);
        p  = ax * bx;
        return p[ACC_W-1:0];
    endfunction

    // Row i of A and column i of B are delayed i cycles on entry.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_row[D_W-1:0] = a_in[D_W-1:0];
            assign b_col[D_W-1:0] = b_in[D_W-1:0];
        end else begin : g_dly
            logic [D_W-1:0] sa_q [i];
            logic [D_W-1:0] sa_d [i];
            logic [D_W-1:0] sb_q [i];
            logic [D_W-1:0] sb_d [i];

            // Shift the skew delay line by one stage.
            always_comb begin
                sa_d[0] = a_in[i*D_W +: D_W];
                sb_d[0] = b_in[i*D_W +: D_W];
                for (int d = 1; d < i; d++) begin
                    sa_d[d] = sa_q[d-1];
                    sb_d[d] = sb_q[d-1];
                end
            end

            // Skew delay registers.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sa_q <= '{default: '0};
                    sb_q <= '{default: '0};
                end else begin
                    sa_q <= sa_d;
                    sb_q <= sb_d;
                end
            end

            assign a_row[i*D_W +: D_W] = sa_q[i-1];
            assign b_col[i*D_W +: D_W] = sb_q[i-1];
        end
    end

    // Operands seen by each PE: A flows right, B flows down.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_at[i][0] = a_row[i*D_W +: D_W];
            b_at[0][i] = b_col[i*D_W +: D_W];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                a_at[i][j] = a_pass_q[i][j-1];
                b_at[j][i] = b_pass_q[j-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N - 1; j++) begin
                a_pass_d[i][j] = a_at[i][j];
                b_pass_d[j][i] = b_at[j][i];
            end
        end
    end

    // Multiply-accumulate in every PE, cleared when a job starts.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc_d[i*N+j] = clear ? '0 :
                    acc_q[i*N+j] + mul_ext(a_at[i][j], b_at[i][j], sgn_q);
            end
        end
    end

    // Systolic pass-through registers and accumulators.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_pass_q <= '{default: '0};
            b_pass_q <= '{default: '0};
            acc_q    <= '{default: '0};
        end else begin
            a_pass_q <= a_pass_d;
            b_pass_q <= b_pass_d;
            acc_q    <= acc_d;
        end
    end

    // Job control: next state and registered stream outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        sgn_d       = sgn_q;
        beat_d      = beat_q;
        drain_d     = drain_q;
        elem_d      = elem_q;
        clear       = 1'b0;
        elem_nx     = elem_q + EW'(1);
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clear      = 1'b1;
                    sgn_d      = bus.signed_en;
                    beat_d     = '0;
                    state_d    = LOAD;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            LOAD: begin
                if (fire) begin
                    beat_d = beat_q + BW'(1);
                    if (bus.in_last || beat_q == BW'(K_MAX - 1)) begin
                        state_d    = DRAIN;
                        in_ready_d = 1'b0;
                        drain_d    = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(2 * N - 3)) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q[0];
                    out_last_d  = 1'b0;
                    elem_d      = '0;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (elem_q == EW'(NE - 1)) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        busy_d      = 1'b0;
                    end else begin
                        elem_d     = elem_nx;
                        out_data_d = acc_q[elem_nx];
                        out_last_d = (elem_nx == EW'(NE - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            sgn_q       <= 1'b0;
            beat_q      <= '0;
            drain_q     <= '0;
            elem_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            sgn_q       <= sgn_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
            elem_q      <= elem_d;
        end
    end
endmodule

// File: tb/tb_tpu_stream_core.sv
// Directed bench for tpu_stream_core (N=2, D_W=8, K_MAX=4).
// Each scenario task drives a job and checks results inline.
module tb_tpu_stream_core;
    localparam int D_W   = 8;
    localparam int N     = 2;
    localparam int K_MAX = 4;
    localparam int ACC_W = 18;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    tpu_stream_core_if #(.D_W(D_W), .N(N), .K_MAX(K_MAX)) bus ();

    tpu_stream_core #(.D_W(D_W), .N(N), .K_MAX(K_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic sgn, input string nm);
        bus.start     = 1'b1;
        bus.signed_en = sgn;
        step();
        bus.start = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s start: busy=%b in_ready=%b want 1/1",
                     nm, bus.busy, bus.in_ready);
        end
    endtask

    task automatic send_beat(input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic last, input string nm);
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s beat: in_ready=%b want 1", nm, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_a     = {a1, a0};
        bus.in_b     = {b1, b0};
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic basic_beats(input int gap, input string nm);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 1'b0, nm);
        repeat (gap) step();
        send_beat(8'd2, 8'd4, 8'd7, 8'd8, 1'b1, nm);
    endtask

    // Drains four results; bp applies a stall pattern on out_ready.
    task automatic collect(input logic [ACC_W-1:0] e0,
                           input logic [ACC_W-1:0] e1,
                           input logic [ACC_W-1:0] e2,
                           input logic [ACC_W-1:0] e3,
                           input bit bp, input string nm);
        logic [ACC_W-1:0] exp_v [4];
        logic [7:0]       pat;
        int               idx;
        int               cyc;
        exp_v[0] = e0;
        exp_v[1] = e1;
        exp_v[2] = e2;
        exp_v[3] = e3;
        pat = 8'b1001_0110;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 60) begin
            bus.out_ready = bp ? pat[cyc % 8] : 1'b1;
            if (bus.out_valid === 1'b1) begin
                n_vec++;
                if (bus.out_data !== exp_v[idx] ||
                    bus.out_last !== (idx == 3)) begin
                    n_err++;
                    $display("FAIL %s elem%0d: data=%0d last=%b want %0d/%b",
                             nm, idx, bus.out_data, bus.out_last,
                             exp_v[idx], (idx == 3));
                end
                if (bus.out_ready) idx++;
            end
            step();
            cyc++;
        end
        bus.out_ready = 1'b1;
        n_vec++;
        if (idx != 4) begin
            n_err++;
            $display("FAIL %s timeout: got %0d elems want 4", nm, idx);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s end: out_valid=%b busy=%b want 0/0",
                     nm, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        n_vec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_last !== 1'b0 || bus.out_data !== '0 ||
            bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset: rdy=%b ov=%b ol=%b od=%0d busy=%b want 0",
                     bus.in_ready, bus.out_valid, bus.out_last,
                     bus.out_data, bus.busy);
        end
        rst = 1'b1;
        step();
        n_vec++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b in_ready=%b want 0/0",
                     bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        do_start(1'b0, "basic");
        basic_beats(0, "basic");
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic t+1: in_ready=%b want 0", bus.in_ready);
        end
        step();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic t+2: out_valid=%b want 0", bus.out_valid);
        end
        step();
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic t+3: out_valid=%b want 1", bus.out_valid);
        end
        collect(18'd19, 18'd22, 18'd43, 18'd50, 1'b0, "basic");
    endtask

    task automatic test_signed();
        do_start(1'b1, "signed");
        send_beat(8'hFF, 8'h02, 8'h03, 8'hFC, 1'b1, "signed");
        collect(18'h3FFFD, 18'h00004, 18'h00006, 18'h3FFF8, 1'b0, "signed");
        do_start(1'b0, "unsigned");
        send_beat(8'hFF, 8'h02, 8'h03, 8'hFC, 1'b1, "unsigned");
        collect(18'd765, 18'd64260, 18'd6, 18'd504, 1'b0, "unsigned");
    endtask

    task automatic test_forced_last();
        do_start(1'b0, "forced");
        for (int k = 0; k < 4; k++) begin
            send_beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "forced");
        end
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL forced in_ready: %b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        repeat (2) step();
        bus.in_valid = 1'b0;
        collect(18'd260100, 18'd260100, 18'd260100, 18'd260100, 1'b0,
                "forced");
    endtask

    task automatic test_backpressure();
        do_start(1'b0, "bp");
        basic_beats(0, "bp");
        collect(18'd19, 18'd22, 18'd43, 18'd50, 1'b1, "bp");
    endtask

    task automatic test_reset_mid();
        int seen;
        int cyc;
        do_start(1'b0, "rstmid");
        send_beat(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, "rstmid");
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid async: busy=%b in_ready=%b want 0/0",
                     bus.busy, bus.in_ready);
        end
        repeat (2) step();
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.out_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL rstmid stale: out_valid cycles=%0d want 0", seen);
        end
        do_start(1'b0, "clean");
        basic_beats(0, "clean");
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 18'd19 ||
            bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_out: ov=%b data=%0d busy=%b want 1/19/1",
                     bus.out_valid, bus.out_data, bus.busy);
        end
        collect(18'd19, 18'd22, 18'd43, 18'd50, 1'b0, "clean");
    endtask

    task automatic test_back_to_back();
        do_start(1'b0, "gaps");
        basic_beats(3, "gaps");
        collect(18'd19, 18'd22, 18'd43, 18'd50, 1'b0, "gaps");
        do_start(1'b1, "b2b");
        send_beat(8'hFF, 8'h02, 8'h03, 8'hFC, 1'b1, "b2b");
        collect(18'h3FFFD, 18'h00004, 18'h00006, 18'h3FFF8, 1'b0, "b2b");
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.signed_en = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_signed();
        test_forced_last();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
